// File: rtl/regfile_operand_stage.sv
// 32-entry MIPS register file with post-reset clear sequencer and optional write-to-read bypass.
// Optional debug output wr0_flag is enabled by defining REGFILE_WR0_FLAG_EN.
module regfile_operand_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              regwrite,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
`ifdef REGFILE_WR0_FLAG_EN
  output logic              ready,
  output logic              wr0_flag
`else
  output logic              ready
`endif
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              user_we;
  logic              mem_we;
  logic [4:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  // Entry 0 exists only to keep the index range simple; it is never written or read.
  logic [DATA_W-1:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) state_d = READY;
    end
  end

  assign ready   = (state_q == READY);
  assign user_we = ready && regwrite && (wr_addr != 5'd0);

  // Clear sequencer and write-back share one write port so the array maps onto RAM.
  always_comb begin
    mem_we    = !reset && ((state_q == CLEAR) || user_we);
    mem_waddr = (state_q == CLEAR) ? idx_q : wr_addr;
    mem_wdata = (state_q == CLEAR) ? '0 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] a);
    if (!ready || (a == 5'd0)) return '0;
    if (BYPASS_EN && user_we && (wr_addr == a)) return wr_data;
    return mem[a];
  endfunction

  always_comb begin
    rd1 = read_port(rs_addr);
    rd2 = read_port(rt_addr);
  end

`ifdef REGFILE_WR0_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) wr0_flag <= 1'b0;
    else if (ready && regwrite && (wr_addr == 5'd0)) wr0_flag <= 1'b1;
  end
`endif

endmodule
